// File: rtl/mario_pkg.sv
`default_nettype none
//============================================================================
// Module   : mario_pkg
// Brief    : Shared block-array geometry and scroll sequencer state encoding.
// Revision : 1.0 - initial release
//============================================================================
package mario_pkg;

   localparam int BLOCK_ID_W  = 3;
   localparam int BLOCK_ROWS  = 10;
   localparam int COL_DATA_W  = BLOCK_ID_W * BLOCK_ROWS;   // 30
   localparam int SCREEN_COLS = 10;
   localparam int BLOCK_PX    = 64;
   localparam int FINE_W      = $clog2(BLOCK_PX);           // 6

   // Column sequencer states, 2-bit explicit encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      SHIFT = 2'd3
   } scroll_state_t;

endpackage
`default_nettype wire

// File: rtl/column_fetch.sv
`default_nettype none
//============================================================================
// Module   : column_fetch
// Brief    : Fetches one level column from the ROM and presents it with a
//            one-cycle shift pulse (done). Starts fetching out of reset.
// Revision : 1.0 - initial release
//============================================================================
module column_fetch
   import mario_pkg::*;
#(
   parameter int COL_W   = 8,
   parameter int ROM_LAT = 2
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  start,
   output logic [COL_W-1:0]      rom_addr,
   input  logic [COL_DATA_W-1:0] rom_data,
   output logic                  done,
   output logic [COL_DATA_W-1:0] new_block_id,
   output logic [COL_W:0]        next_col,
   output logic                  busy
);

   localparam int                 c_LAT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(ROM_LAT - 1);

   scroll_state_t         r_state;
   logic [c_LAT_W-1:0]    r_lat;
   logic [COL_W-1:0]      r_rom_addr;
   logic [COL_DATA_W-1:0] r_new_block_id;
   // One bit wider than the ROM address so a level of exactly 2**COL_W
   // columns can still be recognised as finished.
   logic [COL_W:0]        r_next_col;

   // Fetch sequencer: FETCH -> WAIT x ROM_LAT -> SHIFT, chaining on start
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state        <= FETCH;
         r_lat          <= '0;
         r_rom_addr     <= '0;
         r_new_block_id <= '0;
         r_next_col     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) r_state <= FETCH;
            end
            FETCH: begin
               r_rom_addr <= r_next_col[COL_W-1:0];
               r_lat      <= c_LAT_LOAD;
               r_state    <= WAIT;
            end
            WAIT: begin
               if (r_lat == '0) begin
                  r_new_block_id <= rom_data;
                  r_state        <= SHIFT;
               end else begin
                  r_lat <= r_lat - 1'b1;
               end
            end
            SHIFT: begin
               r_next_col <= r_next_col + 1'b1;
               r_state    <= start ? FETCH : IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rom_addr     = r_rom_addr;
   assign new_block_id = r_new_block_id;
   assign next_col     = r_next_col;
   assign done         = (r_state == SHIFT);
   assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: rtl/scroll_controller.sv
`default_nettype none
//============================================================================
// Module   : scroll_controller
// Brief    : Horizontal scroll sequencer. Fills the screen with the first
//            columns after reset, then accumulates per-frame scroll into a
//            fine pixel offset and shifts in a new column on each block
//            boundary crossing.
// Revision : 1.0 - initial release
//============================================================================
module scroll_controller
   import mario_pkg::*;
#(
   parameter int LEVEL_COLS = 256,
   parameter int COL_W      = 8,
   parameter int ROM_LAT    = 2
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  frame_start,
   input  logic [2:0]            scroll_amt,
   output logic [COL_W-1:0]      rom_addr,
   input  logic [COL_DATA_W-1:0] rom_data,
   output logic                  Shift,
   output logic [COL_DATA_W-1:0] new_block_id,
   output logic [FINE_W-1:0]     fine_x,
   output logic                  busy,
   output logic                  level_end,
   output logic                  frame_drop
);

   localparam int                 c_FILL_W   = $clog2(SCREEN_COLS);
   localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(SCREEN_COLS - 1);

   logic [COL_W:0]        w_next_col;
   logic [FINE_W:0]       w_sum;
   logic                  w_accept;
   logic                  w_scroll_go;
   logic                  w_fill_more;
   logic                  w_start;

   logic                  r_filling;
   logic [c_FILL_W-1:0]   r_fill_cnt;
   logic [FINE_W-1:0]     r_fine_x;
   logic [FINE_W-1:0]     r_pending_fx;
   logic                  r_frame_drop;

   column_fetch #(
      .COL_W   (COL_W),
      .ROM_LAT (ROM_LAT)
   ) u_column_fetch (
      .Clk          (Clk),
      .Reset        (Reset),
      .start        (w_start),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .done         (Shift),
      .new_block_id (new_block_id),
      .next_col     (w_next_col),
      .busy         (busy)
   );

   assign w_sum       = {1'b0, r_fine_x} + (FINE_W+1)'(scroll_amt);
   assign level_end   = (w_next_col == (COL_W+1)'(LEVEL_COLS));
   assign w_accept    = frame_start && !busy && !level_end;
   assign w_scroll_go = w_accept && (w_sum >= (FINE_W+1)'(BLOCK_PX));
   // During fill every shift immediately chains the next fetch until the
   // last screen column has been loaded.
   assign w_fill_more = Shift && r_filling && (r_fill_cnt != c_FILL_LAST);
   assign w_start     = w_scroll_go || w_fill_more;

   // The new offset is shown in the shift cycle itself so the renderer sees
   // the column move and the offset wrap together.
   assign fine_x      = (Shift && !r_filling) ? r_pending_fx : r_fine_x;
   assign frame_drop  = r_frame_drop;

   // Fill tracking, fine offset accumulation and dropped-frame flag
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_filling    <= 1'b1;
         r_fill_cnt   <= '0;
         r_fine_x     <= '0;
         r_pending_fx <= '0;
         r_frame_drop <= 1'b0;
      end else begin
         r_frame_drop <= frame_start && busy;

         if (Shift && r_filling) begin
            if (r_fill_cnt == c_FILL_LAST) r_filling  <= 1'b0;
            else                           r_fill_cnt <= r_fill_cnt + 1'b1;
         end

         if (Shift && !r_filling) begin
            r_fine_x <= r_pending_fx;
         end else if (w_accept) begin
            // sum is below 2*BLOCK_PX, so dropping the top bit is sum-64
            if (w_scroll_go) r_pending_fx <= w_sum[FINE_W-1:0];
            else             r_fine_x     <= w_sum[FINE_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire
